reaction_ctrl_fsm: RTL and testbench
====================================

// Module: reaction_ctrl_fsm
// PURPOSE
//  Control FSM for the reaction timer; sits directly upstream of the delay/BCD counter.
//  - Runs a random fore-period, then lights the stimulus LED.
//  - Sequences the counter's time_clr / record_wait / stop controls.
//  - Flags an early press (during fore-period) or a late response (counter overflow).
// PARAMETERS
//  TICK_DIV   1000  clk cycles per fore-period tick (must be >= 2)
//  MIN_DLY    500   minimum fore-period, in ticks
//  RAND_BITS  10    random extra fore-period = lfsr[RAND_BITS-1:0] ticks (RAND_BITS <= 16)
//  SEED       16'hACE1  LFSR reset value (must be nonzero)
// PORTS
//  clk          in   1  system clock, rising edge
//  rst_n        in   1  asynchronous, active-low reset
//  start        in   1  single-cycle pulse from synced/debounced start button
//  stop_btn     in   1  single-cycle pulse from synced/debounced response button
//  err_long     in   1  counter's error_long_delay flag (level)
//  time_clr     out  1  counter clear
//  record_wait  out  1  counter count-enable
//  stop         out  1  counter freeze/hold
//  led          out  1  stimulus lamp
//  err_early    out  1  early-press indicator (level)
//  err_late     out  1  late-response indicator (level)
// BEHAVIOUR
//  Clocking/reset: one clock domain; asynchronous active-low reset.
//  Outputs: Moore, decoded combinationally from the state register only.
//  Reset: state=IDLE, lfsr=SEED, prescaler=0, delay count=0.
//   Output values at reset: time_clr=1; all other outputs 0.
//  LFSR:
//   - 16-bit Fibonacci, taps 16,14,13,11; shifts every cycle and never reaches 0.
//   - Sampled only in CLEAR.
//  States (outputs given as tc/rw/st/led/ee/el):
//   IDLE      1/0/0/0/0/0. start -> CLEAR.
//   CLEAR     1/0/0/0/0/0. Exactly one cycle.
//             dly <= MIN_DLY + lfsr[RAND_BITS-1:0]; prescaler <= 0. -> WAIT_RAND.
//   WAIT_RAND 0/0/0/0/0/0. Prescaler counts 0..TICK_DIV-1; tick at TICK_DIV-1.
//             dly decrements on each tick.
//             stop_btn -> ERR_EARLY (priority over the tick).
//             Tick with dly==1 -> TIMING.
//             Fore-period = dly*TICK_DIV cycles, measured from the CLEAR exit.
//   TIMING    0/1/0/1/0/0.
//             stop_btn -> SHOW.
//             err_long -> ERR_LATE. If both in the same cycle, stop_btn wins.
//   SHOW      0/0/1/0/0/0. Holds the result. start -> CLEAR.
//   ERR_EARLY 1/0/0/0/1/0. start -> CLEAR.
//   ERR_LATE  0/0/1/0/0/1. start -> CLEAR.
//  Ignored inputs:
//   - start is ignored in CLEAR, WAIT_RAND and TIMING.
//   - stop_btn is ignored in IDLE, SHOW and the ERR states.
//  Simultaneous start+stop_btn: in IDLE/SHOW/ERR start acts; in WAIT_RAND/TIMING stop_btn acts.
//  Reset asserted mid-operation: immediately returns to IDLE outputs.
//   LFSR reloads SEED, so the delay sequence is deterministic after reset.
//  Widths:
//   - dly width = $clog2(MIN_DLY + 2**RAND_BITS) + 1.
//   - Prescaler width = $clog2(TICK_DIV).
//   - All arithmetic unsigned; no overflow is possible.
//  Undefined state encodings -> IDLE.
// STRUCTURE
//  rt_pkg:
//   - typedef enum logic [2:0] rt_state_t {IDLE, CLEAR, WAIT_RAND, TIMING, SHOW, ERR_EARLY, ERR_LATE}
//   - localparam RT_LFSR_TAPS = 16'hB400
//  Sub-module rt_lfsr (clk, rst_n, SEED -> q[15:0]); prescaler and dly counter stay in the top.
// TESTING (TICK_DIV=4, MIN_DLY=2, RAND_BITS=2, CLK_PD=10)
//  1. rst_n low mid-TIMING
//     -> same cycle: time_clr=1, led=0, record_wait=0; after release, IDLE.
//  2. start at cycle 3, no press
//     -> CLEAR for 1 cycle.
//     -> led rises exactly dly*4 cycles later, with dly = 2 + lfsr[1:0] from the bench model.
//     -> dly lies in 2..5.
//  3. Path (2), then stop_btn 7 cycles after led rose
//     -> record_wait high for 7 cycles, then stop=1, led=0, state SHOW held until start.
//  4. stop_btn 1 cycle into WAIT_RAND
//     -> next cycle: err_early=1, time_clr=1, led never rises; start then -> CLEAR.
//  5. In TIMING, err_long=1 with no press -> err_late=1, stop=1, record_wait=0.
//     Repeat with err_long and stop_btn in the same cycle -> SHOW, err_late stays 0.
//  6. Back-to-back runs from SHOW
//     -> each CLEAR samples a new lfsr value; the delays match the model for 8 runs.
//     start pulses during WAIT_RAND/TIMING have no effect.

Source files
------------

// File: rtl/rt_pkg.sv
// Shared types and constants for the reaction-timer control FSM.
package rt_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CLEAR     = 3'd1,
        WAIT_RAND = 3'd2,
        TIMING    = 3'd3,
        SHOW      = 3'd4,
        ERR_EARLY = 3'd5,
        ERR_LATE  = 3'd6
    } rt_state_t;

    // Feedback taps at positions 16,14,13,11 (bit 15 = position 16).
    localparam logic [15:0] RT_LFSR_TAPS = 16'hB400;

    typedef struct packed {
        logic time_clr;
        logic record_wait;
        logic stop;
        logic led;
        logic err_early;
        logic err_late;
    } rt_out_t;

    localparam rt_out_t RT_OUT_IDLE = '{time_clr: 1'b1, default: 1'b0};

endpackage

// File: rtl/rt_lfsr.sv
// Free-running 16-bit Fibonacci LFSR; a nonzero seed keeps it off the all-zero lockup state.
module rt_lfsr
    import rt_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] q
);

    // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= SEED;
        end else begin
            q <= {q[14:0], ^(q & RT_LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/reaction_ctrl_fsm.sv
// Reaction-timer control: random fore-period, stimulus lamp, counter sequencing
// and early/late error flags.
module reaction_ctrl_fsm
    import rt_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 1000,
    parameter int unsigned MIN_DLY   = 500,
    parameter int unsigned RAND_BITS = 10,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic stop_btn,
    input  logic err_long,
    output logic time_clr,
    output logic record_wait,
    output logic stop,
    output logic led,
    output logic err_early,
    output logic err_late
);

    localparam int unsigned DLY_W = $clog2(MIN_DLY + 2**RAND_BITS) + 1;
    localparam int unsigned PRE_W = $clog2(TICK_DIV);

    rt_state_t        state;
    rt_state_t        state_next;
    rt_out_t          outs;
    logic [15:0]      lfsr;
    logic [PRE_W-1:0] prescaler;
    logic [DLY_W-1:0] dly;
    logic             tick;

    rt_lfsr #(.SEED(SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (lfsr)
    );

    // Only the low RAND_BITS of the LFSR feed the fore-period.
    if (RAND_BITS < 16) begin : g_lfsr_unused
        logic lfsr_hi_unused;
        assign lfsr_hi_unused = ^lfsr[15:RAND_BITS];
    end

    assign tick = (state == WAIT_RAND) && (prescaler == PRE_W'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
            dly       <= '0;
        end else if (state == CLEAR) begin
            prescaler <= '0;
            dly       <= DLY_W'(MIN_DLY) + DLY_W'(lfsr[RAND_BITS-1:0]);
        end else if (state == WAIT_RAND) begin
            prescaler <= tick ? '0 : prescaler + 1'b1;
            if (tick) begin
                dly <= dly - 1'b1;
            end
        end
    end

    // NOTE: default assignment first in every combinational block, so no path infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (start) state_next = CLEAR;
            CLEAR:     state_next = WAIT_RAND;
            WAIT_RAND: begin
                if (stop_btn) begin
                    state_next = ERR_EARLY;
                end else if (tick && dly == DLY_W'(1)) begin
                    state_next = TIMING;
                end
            end
            TIMING: begin
                if (stop_btn) begin
                    state_next = SHOW;
                end else if (err_long) begin
                    state_next = ERR_LATE;
                end
            end
            SHOW, ERR_EARLY, ERR_LATE: if (start) state_next = CLEAR;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        outs = RT_OUT_IDLE;
        case (state)
            IDLE, CLEAR: outs = RT_OUT_IDLE;
            WAIT_RAND:   outs = '0;
            TIMING:      outs = '{record_wait: 1'b1, led: 1'b1, default: 1'b0};
            SHOW:        outs = '{stop: 1'b1, default: 1'b0};
            ERR_EARLY:   outs = '{time_clr: 1'b1, err_early: 1'b1, default: 1'b0};
            ERR_LATE:    outs = '{stop: 1'b1, err_late: 1'b1, default: 1'b0};
            default:     outs = RT_OUT_IDLE;
        endcase
    end

    assign time_clr    = outs.time_clr;
    assign record_wait = outs.record_wait;
    assign stop        = outs.stop;
    assign led         = outs.led;
    assign err_early   = outs.err_early;
    assign err_late    = outs.err_late;

endmodule

// File: tb/tb_reaction_ctrl_fsm.sv
// Self-checking bench for reaction_ctrl_fsm: a cycle-count model of the fore-period
// driven by a software LFSR, with randomized press timing and start noise.
module tb_reaction_ctrl_fsm;

    localparam int unsigned TICK_DIV  = 4;
    localparam int unsigned MIN_DLY   = 2;
    localparam int unsigned RAND_BITS = 2;
    localparam logic [15:0] SEED      = 16'hACE1;
    localparam int          BOUND     = TICK_DIV * (MIN_DLY + 2**RAND_BITS) + 20;

    // Expected output vectors {time_clr, record_wait, stop, led, err_early, err_late}.
    localparam logic [5:0] O_IDLE   = 6'b100000;
    localparam logic [5:0] O_WAIT   = 6'b000000;
    localparam logic [5:0] O_TIMING = 6'b010100;
    localparam logic [5:0] O_SHOW   = 6'b001000;
    localparam logic [5:0] O_EE     = 6'b100010;
    localparam logic [5:0] O_EL     = 6'b001001;

    logic clk = 1'b0;
    logic rst_n;
    logic start, stop_btn, err_long;
    logic time_clr, record_wait, stop, led, err_early, err_late;
    logic [5:0] outs;

    int checks   = 0;
    int failures = 0;

    logic [15:0] m_lfsr;

    reaction_ctrl_fsm #(
        .TICK_DIV  (TICK_DIV),
        .MIN_DLY   (MIN_DLY),
        .RAND_BITS (RAND_BITS),
        .SEED      (SEED)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stop_btn    (stop_btn),
        .err_long    (err_long),
        .time_clr    (time_clr),
        .record_wait (record_wait),
        .stop        (stop),
        .led         (led),
        .err_early   (err_early),
        .err_late    (err_late)
    );

    always #5 clk = ~clk;

    assign outs = {time_clr, record_wait, stop, led, err_early, err_late};

    // Software LFSR: shift left, new bit = XOR of positions 16,14,13,11.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        int fb;
        fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
        return 16'(((v << 1) | fb) & 16'hFFFF);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= SEED;
        else        m_lfsr <= lfsr_step(m_lfsr);
    end

    // Pulse start (optionally with stop_btn) and land on the CLEAR cycle; check it, then
    // step to the first fore-period cycle and return the model's tick count.
    task automatic begin_run(input string name, input bit with_stop, output int exp_dly);
        @(negedge clk);
        start    = 1'b1;
        stop_btn = with_stop;
        @(negedge clk);
        start    = 1'b0;
        stop_btn = 1'b0;
        exp_dly  = MIN_DLY + int'(m_lfsr % (2**RAND_BITS));
        checks++;
        if (outs !== O_IDLE) begin
            failures++;
            $display("FAIL %s clear_outs: got %b want %b", name, outs, O_IDLE);
        end
        @(negedge clk);
        checks++;
        if (outs !== O_WAIT) begin
            failures++;
            $display("FAIL %s clear_one_cycle: got %b want %b", name, outs, O_WAIT);
        end
    endtask

    // From fore-period cycle 1, count cycles until the lamp lights.
    task automatic wait_led(input string name, input int exp_dly, input bit noise);
        int cnt = 0;
        while (led !== 1'b1 && cnt < BOUND) begin
            cnt++;
            if (noise) start = ($urandom_range(0, 3) == 0);
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (cnt != exp_dly * int'(TICK_DIV) || outs !== O_TIMING) begin
            failures++;
            $display("FAIL %s fore_period: got %0d cycles outs %b want %0d cycles outs %b",
                     name, cnt, outs, exp_dly * int'(TICK_DIV), O_TIMING);
        end
    endtask

    // From TIMING cycle 1, press on cycle n and expect SHOW.
    task automatic press_after(input string name, input int n, input bit noise);
        int hi = 0;
        for (int i = 1; i <= n; i++) begin
            if (record_wait === 1'b1) hi++;
            if (i < n) begin
                if (noise) start = ($urandom_range(0, 2) == 0);
                @(negedge clk);
            end
        end
        stop_btn = 1'b1;
        @(negedge clk);
        stop_btn = 1'b0;
        start    = 1'b0;
        checks++;
        if (hi != n || outs !== O_SHOW) begin
            failures++;
            $display("FAIL %s press: got rw_cycles %0d outs %b want %0d outs %b",
                     name, hi, outs, n, O_SHOW);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; stop_btn = 1'b0; err_long = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (outs !== O_IDLE) begin
            failures++;
            $display("FAIL reset_outs: got %b want %b", outs, O_IDLE);
        end
        rst_n = 1'b1;
        stop_btn = 1'b1;
        @(negedge clk);
        stop_btn = 1'b0;
        @(negedge clk);
        checks++;
        if (outs !== O_IDLE) begin
            failures++;
            $display("FAIL idle_ignores_stop: got %b want %b", outs, O_IDLE);
        end
    endtask

    task automatic test_single_run();
        int d;
        begin_run("single", 1'b0, d);
        wait_led("single", d, 1'b0);
        press_after("single", 7, 1'b0);
        repeat (6) @(negedge clk);
        checks++;
        if (outs !== O_SHOW) begin
            failures++;
            $display("FAIL show_hold: got %b want %b", outs, O_SHOW);
        end
    endtask

    task automatic test_early();
        int d;
        int led_seen = 0;
        begin_run("early", 1'b1, d);
        stop_btn = 1'b1;
        @(negedge clk);
        stop_btn = 1'b0;
        checks++;
        if (outs !== O_EE) begin
            failures++;
            $display("FAIL early_flag: got %b want %b", outs, O_EE);
        end
        repeat (30) begin
            @(negedge clk);
            if (led === 1'b1) led_seen++;
        end
        checks++;
        if (led_seen != 0 || outs !== O_EE) begin
            failures++;
            $display("FAIL early_hold: got led_cycles %0d outs %b want 0 outs %b",
                     led_seen, outs, O_EE);
        end
        begin_run("early_restart", 1'b0, d);
        wait_led("early_restart", d, 1'b0);
        press_after("early_restart", 2, 1'b0);
    endtask

    task automatic test_late();
        int d;
        begin_run("late", 1'b0, d);
        wait_led("late", d, 1'b0);
        err_long = 1'b1;
        @(negedge clk);
        err_long = 1'b0;
        checks++;
        if (outs !== O_EL) begin
            failures++;
            $display("FAIL late_flag: got %b want %b", outs, O_EL);
        end
        stop_btn = 1'b1;
        @(negedge clk);
        stop_btn = 1'b0;
        @(negedge clk);
        checks++;
        if (outs !== O_EL) begin
            failures++;
            $display("FAIL late_ignores_stop: got %b want %b", outs, O_EL);
        end
        begin_run("late_tie", 1'b0, d);
        wait_led("late_tie", d, 1'b0);
        err_long = 1'b1;
        stop_btn = 1'b1;
        @(negedge clk);
        err_long = 1'b0;
        stop_btn = 1'b0;
        checks++;
        if (outs !== O_SHOW) begin
            failures++;
            $display("FAIL late_tie_stop_wins: got %b want %b", outs, O_SHOW);
        end
    endtask

    task automatic test_reset_mid_timing();
        int d;
        begin_run("rst_mid", 1'b0, d);
        wait_led("rst_mid", d, 1'b0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (outs !== O_IDLE) begin
            failures++;
            $display("FAIL reset_mid_timing: got %b want %b", outs, O_IDLE);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (outs !== O_IDLE) begin
            failures++;
            $display("FAIL reset_release_idle: got %b want %b", outs, O_IDLE);
        end
        // Fore-period after reset must follow the reseeded LFSR.
        begin_run("post_reset", 1'b0, d);
        wait_led("post_reset", d, 1'b0);
        press_after("post_reset", 1, 1'b0);
    endtask

    task automatic test_back_to_back();
        int d;
        for (int r = 0; r < 8; r++) begin
            begin_run($sformatf("b2b%0d", r), r[0], d);
            wait_led($sformatf("b2b%0d", r), d, 1'b1);
            press_after($sformatf("b2b%0d", r), int'($urandom_range(1, 10)), 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_single_run();
        test_early();
        test_late();
        test_reset_mid_timing();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
